// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg
//   Items shared by the SGDMAC APB requester and the SGDMAC_CFG register slave.
//   - APB_ADDR_W / APB_DATA_W : APB bus widths used on both sides of the bus.
//   - apb_req_state_e         : requester FSM states (IDLE/SETUP/ACCESS/RESP).
//   - apb_rsp_t               : one response as returned on the response stream.
package sgdmac_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/sgdmac_apb_requester.sv
// sgdmac_apb_requester
//   APB3 requester. Turns one command from a valid/ready stream into one
//   APB transfer and returns the outcome on a valid/ready response stream.
//   Misaligned addresses are rejected without touching the bus, and a stuck
//   slave is abandoned after TIMEOUT_CYCLES wait states (0 disables this).
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i                    command payload
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                  response payload
//   psel_o, penable_o, paddr_o,
//   pwrite_o, pwdata_o             APB request side
//   pready_i, prdata_i, pslverr_i  APB completion side
module sgdmac_apb_requester
  import sgdmac_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i
);

  // A width of at least one bit keeps the counter legal when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_req_state_e    state_q;
  apb_rsp_t          rsp_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cmd_fire;
  logic              cmd_aligned;

  // A finished response can be retired and replaced in the same cycle,
  // which is what allows back-to-back transfers.
  assign cmd_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign cmd_aligned = (cmd_addr_i[1:0] == 2'b00);

  // Bus strobes are decoded straight from the state register so that reset
  // removes them without waiting for a clock edge.
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign rsp_valid_o   = (state_q == RESP);
  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rsp_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (cmd_fire) begin
        if (cmd_aligned) begin
          paddr_q  <= cmd_addr_i;
          pwrite_q <= cmd_write_i;
          pwdata_q <= cmd_wdata_i;
          cnt_q    <= '0;
          state_q  <= SETUP;
        end else begin
          rsp_q   <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
          state_q <= RESP;
        end
      end else begin
        case (state_q)
          SETUP: state_q <= ACCESS;
          ACCESS: begin
            // A ready slave wins over a timeout that expires in the same cycle.
            if (pready_i) begin
              rsp_q.rdata   <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
              rsp_q.err     <= pslverr_i;
              rsp_q.timeout <= 1'b0;
              state_q       <= RESP;
            end else begin
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
              end
              // cnt_q counts earlier wait cycles, so CNT_LAST marks the final allowed one.
              if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                rsp_q   <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
                state_q <= RESP;
              end
            end
          end
          RESP: begin
            if (rsp_ready_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sgdmac_apb_requester.sv
// tb_sgdmac_apb_requester
//   Directed bench for sgdmac_apb_requester with TIMEOUT_CYCLES=8. The bench
//   plays the APB slave by driving pready/prdata/pslverr cycle by cycle.
//   Inputs change 1ns after a rising edge and outputs are checked there.
module tb_sgdmac_apb_requester;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o, rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o, rsp_timeout_o;
  logic              psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i, pslverr_i;
  logic [DATA_W-1:0] prdata_i;

  int errors = 0;
  int checks = 0;
  int count;

  sgdmac_apb_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = data;
  endtask

  // Hang guard: should never fire.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;

    // Reset state
    #12;
    check_output("reset_psel", psel_o, 0);
    check_output("reset_penable", penable_o, 0);
    check_output("reset_rsp_valid", rsp_valid_o, 0);
    check_output("reset_paddr", paddr_o, 0);
    check_output("reset_pwdata", pwdata_o, 0);
    check_output("reset_rsp_err", rsp_err_o, 0);
    rst_n = 1'b1;
    step();
    check_output("idle_cmd_ready", cmd_ready_o, 1);

    // 1. Zero-wait write 0x100 <- 0xDEADBEEF
    $display("[TB] test 1: zero-wait write");
    send_cmd(1'b1, 12'h100, 32'hDEAD_BEEF);
    pready_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    check_output("t1_setup_psel", psel_o, 1);
    check_output("t1_setup_penable", penable_o, 0);
    check_output("t1_paddr", paddr_o, 12'h100);
    check_output("t1_pwrite", pwrite_o, 1);
    check_output("t1_pwdata", pwdata_o, 32'hDEAD_BEEF);
    check_output("t1_setup_cmd_ready", cmd_ready_o, 0);
    step();
    check_output("t1_access_psel", psel_o, 1);
    check_output("t1_access_penable", penable_o, 1);
    check_output("t1_access_rsp_valid", rsp_valid_o, 0);
    step();
    check_output("t1_rsp_valid", rsp_valid_o, 1);
    check_output("t1_rsp_psel", psel_o, 0);
    check_output("t1_rsp_err", rsp_err_o, 0);
    check_output("t1_rsp_rdata", rsp_rdata_o, 0);
    check_output("t1_rsp_cmd_ready_noack", cmd_ready_o, 0);
    rsp_ready_i = 1'b1;
    #1;
    check_output("t1_rsp_cmd_ready_ack", cmd_ready_o, 1);
    step();
    rsp_ready_i = 1'b0;
    check_output("t1_back_idle", rsp_valid_o, 0);

    // 2. Read 0x104 with 3 wait states
    $display("[TB] test 2: read with 3 wait states");
    pready_i = 1'b0;
    prdata_i = 32'hAAAA_5555;
    send_cmd(1'b0, 12'h104, 32'h0);
    step();
    cmd_valid_i = 1'b0;
    check_output("t2_setup_penable", penable_o, 0);
    count = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (penable_o === 1'b1) count++;
      check_output("t2_paddr_stable", paddr_o, 12'h104);
      check_output("t2_pwrite_stable", pwrite_o, 0);
      if (k == 4) begin
        pready_i = 1'b1;
        prdata_i = 32'h1234_5678;
      end
    end
    check_output("t2_penable_cycles", count, 4);
    step();
    check_output("t2_rsp_valid", rsp_valid_o, 1);
    check_output("t2_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
    check_output("t2_rsp_err", rsp_err_o, 0);
    check_output("t2_rsp_timeout", rsp_timeout_o, 0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // 3. Read with pslverr on the ready cycle
    $display("[TB] test 3: slave error");
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hFFFF_FFFF;
    send_cmd(1'b0, 12'h108, 32'h0);
    step();
    cmd_valid_i = 1'b0;
    step();
    step();
    check_output("t3_rsp_valid", rsp_valid_o, 1);
    check_output("t3_rsp_err", rsp_err_o, 1);
    check_output("t3_rsp_timeout", rsp_timeout_o, 0);
    check_output("t3_rsp_rdata", rsp_rdata_o, 0);
    pslverr_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // 4. Timeout with pready stuck low
    $display("[TB] test 4: timeout");
    pready_i = 1'b0;
    prdata_i = 32'hCAFE_F00D;
    send_cmd(1'b0, 12'h10C, 32'h0);
    step();
    cmd_valid_i = 1'b0;
    count = 0;
    for (int g = 0; g < 20; g++) begin
      step();
      if (rsp_valid_o === 1'b1) break;
      if (penable_o === 1'b1) count++;
    end
    check_output("t4_rsp_valid", rsp_valid_o, 1);
    check_output("t4_access_cycles", count, 8);
    check_output("t4_psel_dropped", psel_o, 0);
    check_output("t4_rsp_err", rsp_err_o, 1);
    check_output("t4_rsp_timeout", rsp_timeout_o, 1);
    check_output("t4_rsp_rdata", rsp_rdata_o, 0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // 5. Misaligned command, then response held under backpressure
    $display("[TB] test 5: misaligned address");
    send_cmd(1'b1, 12'h102, 32'h0BAD_0BAD);
    step();
    cmd_valid_i = 1'b0;
    check_output("t5_psel", psel_o, 0);
    check_output("t5_rsp_valid", rsp_valid_o, 1);
    check_output("t5_rsp_err", rsp_err_o, 1);
    check_output("t5_rsp_timeout", rsp_timeout_o, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_output("t5_hold_rsp_valid", rsp_valid_o, 1);
      check_output("t5_hold_rsp_err", rsp_err_o, 1);
      check_output("t5_hold_rdata", rsp_rdata_o, 0);
      check_output("t5_hold_psel", psel_o, 0);
      check_output("t5_hold_cmd_ready", cmd_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check_output("t5_back_idle", rsp_valid_o, 0);

    // 6. Back-to-back writes, then reset during ACCESS
    $display("[TB] test 6: back-to-back and async reset");
    pready_i    = 1'b1;
    rsp_ready_i = 1'b1;
    send_cmd(1'b1, 12'h200, 32'h1111_2222);
    step();
    send_cmd(1'b1, 12'h204, 32'h3333_4444);
    check_output("t6_setup1_psel", psel_o, 1);
    check_output("t6_setup1_cmd_ready", cmd_ready_o, 0);
    step();
    check_output("t6_access1_penable", penable_o, 1);
    step();
    check_output("t6_rsp1_valid", rsp_valid_o, 1);
    check_output("t6_rsp1_cmd_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    pready_i    = 1'b0;
    check_output("t6_setup2_psel", psel_o, 1);
    check_output("t6_setup2_penable", penable_o, 0);
    check_output("t6_setup2_paddr", paddr_o, 12'h204);
    check_output("t6_setup2_pwdata", pwdata_o, 32'h3333_4444);
    check_output("t6_setup2_rsp_valid", rsp_valid_o, 0);
    step();
    check_output("t6_access2_penable", penable_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_psel", psel_o, 0);
    check_output("t6_rst_penable", penable_o, 0);
    check_output("t6_rst_rsp_valid", rsp_valid_o, 0);
    check_output("t6_rst_paddr", paddr_o, 0);
    #6;
    rst_n = 1'b1;
    rsp_ready_i = 1'b0;
    step();
    check_output("t6_post_rst_cmd_ready", cmd_ready_o, 1);
    check_output("t6_post_rst_rsp_valid", rsp_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
